// File: rtl/iir_lpf_mc_pkg.sv
// Shared width derivations and shift clamping for the multi-channel IIR low-pass filter.
package iir_lpf_mc_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

    function automatic int sig_w(input int dat_w, input int shift_max);
        return dat_w + shift_max;
    endfunction

    function automatic int ch_w(input int ch);
        return (clog2(ch) < 1) ? 1 : clog2(ch);
    endfunction

    function automatic int sh_w(input int shift_max);
        return clog2(shift_max + 1);
    endfunction

    function automatic int clamp_shift(input int s, input int shift_max);
        return (s > shift_max) ? shift_max : s;
    endfunction

endpackage

// File: rtl/iir_lpf_upd.sv
// Combinational state update: SIGMA' = SIGMA + ((DAT<<F)>>s) - (SIGMA>>s), or a seed of DAT<<F on load.
module iir_lpf_upd
    import iir_lpf_mc_pkg::*;
#(
    parameter int C_DAT_W     = 8,
    parameter int C_SHIFT_MAX = 8,
    parameter int C_SIGNED    = 0,
    localparam int C_SIG_W    = sig_w(C_DAT_W, C_SHIFT_MAX),
    localparam int C_SH_W     = sh_w(C_SHIFT_MAX)
) (
    input  logic [C_SIG_W-1:0] sigma,
    input  logic [C_DAT_W-1:0] dat,
    input  logic [C_SH_W-1:0]  shift,
    input  logic               load,
    output logic [C_SIG_W-1:0] sigma_next
);

    localparam int EXT_W = C_SIG_W + 1;

    logic [C_SH_W-1:0] s_eff;
    logic [EXT_W-1:0]  sig_ext;
    logic [EXT_W-1:0]  dat_ext;
    logic [EXT_W-1:0]  sig_sh;
    logic [EXT_W-1:0]  dat_sh;

    // One guard bit keeps the intermediate sum exact; the final value always fits C_SIG_W.
    always_comb begin
        s_eff   = C_SH_W'(clamp_shift(int'(shift), C_SHIFT_MAX));
        sig_ext = {1'b0, sigma};
        dat_ext = '0;
        dat_ext[C_SIG_W-1:C_SHIFT_MAX] = dat;
        if (C_SIGNED != 0) begin
            sig_ext[C_SIG_W] = sigma[C_SIG_W-1];
            dat_ext[C_SIG_W] = dat[C_DAT_W-1];
            sig_sh = $signed(sig_ext) >>> s_eff;
            dat_sh = $signed(dat_ext) >>> s_eff;
        end else begin
            sig_sh = sig_ext >> s_eff;
            dat_sh = dat_ext >> s_eff;
        end
        if (load) begin
            sigma_next = dat_ext[C_SIG_W-1:0];
        end else begin
            sigma_next = C_SIG_W'(sig_ext + dat_sh - sig_sh);
        end
    end

endmodule

// File: rtl/iir_lpf_mc.sv
// Time-multiplexed first-order IIR low-pass filter: per-channel state file, one shared
// update datapath, valid/ready input and a single registered output beat with backpressure.
module iir_lpf_mc
    import iir_lpf_mc_pkg::*;
#(
    parameter int C_DAT_W     = 8,
    parameter int C_CH        = 4,
    parameter int C_SHIFT_MAX = 8,
    parameter int C_SIGNED    = 0,
    localparam int C_SIG_W    = sig_w(C_DAT_W, C_SHIFT_MAX),
    localparam int C_CH_W     = ch_w(C_CH),
    localparam int C_SH_W     = sh_w(C_SHIFT_MAX)
) (
    input  logic               CK_i,
    input  logic               RST_i,
    input  logic               EN_CK_i,
    input  logic               CLR_i,
    input  logic               IN_VLD_i,
    output logic               IN_RDY_o,
    input  logic [C_CH_W-1:0]  IN_CH_i,
    input  logic [C_DAT_W-1:0] DAT_i,
    input  logic [C_SH_W-1:0]  SHIFT_i,
    input  logic               LOAD_i,
    output logic               OUT_VLD_o,
    input  logic               OUT_RDY_i,
    output logic [C_CH_W-1:0]  OUT_CH_o,
    output logic [C_DAT_W-1:0] QQ_o,
    output logic [C_SIG_W-1:0] SIGMA_o
);

    logic [C_SIG_W-1:0] state [C_CH];
    logic [C_SIG_W-1:0] cur_sigma;
    logic [C_SIG_W-1:0] next_sigma;
    logic               in_rdy;
    logic               accept;

    // A beat may enter whenever the output slot is empty or being drained this same edge.
    assign in_rdy    = EN_CK_i & ~RST_i & ~CLR_i & (~OUT_VLD_o | OUT_RDY_i);
    assign accept    = IN_VLD_i & in_rdy;
    assign IN_RDY_o  = in_rdy;
    assign cur_sigma = state[IN_CH_i];

    iir_lpf_upd #(
        .C_DAT_W     (C_DAT_W),
        .C_SHIFT_MAX (C_SHIFT_MAX),
        .C_SIGNED    (C_SIGNED)
    ) u_upd (
        .sigma      (cur_sigma),
        .dat        (DAT_i),
        .shift      (SHIFT_i),
        .load       (LOAD_i),
        .sigma_next (next_sigma)
    );

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            for (int i = 0; i < C_CH; i++) begin
                state[i] <= '0;
            end
            OUT_VLD_o <= 1'b0;
            OUT_CH_o  <= '0;
            QQ_o      <= '0;
            SIGMA_o   <= '0;
        end else if (EN_CK_i) begin
            if (CLR_i) begin
                for (int i = 0; i < C_CH; i++) begin
                    state[i] <= '0;
                end
            end else if (accept) begin
                state[IN_CH_i] <= next_sigma;
            end
            // Clear never touches the output slot, so a pending beat still drains.
            if (accept) begin
                OUT_VLD_o <= 1'b1;
                OUT_CH_o  <= IN_CH_i;
                QQ_o      <= next_sigma[C_SIG_W-1:C_SHIFT_MAX];
                SIGMA_o   <= next_sigma;
            end else if (OUT_RDY_i) begin
                OUT_VLD_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iir_lpf_mc.sv
// Self-checking bench for iir_lpf_mc: unsigned instance against an arithmetic reference
// model, plus a signed instance checked against fixed expected values.
module tb_iir_lpf_mc;

    localparam int DW  = 8;
    localparam int CH  = 4;
    localparam int SM  = 8;
    localparam int SW  = 16;
    localparam int CHW = 2;
    localparam int SHW = 4;

    logic           ck = 1'b0;
    logic           rst, en, clr, out_rdy;
    logic           in_vld, load;
    logic [CHW-1:0] in_ch;
    logic [DW-1:0]  dat;
    logic [SHW-1:0] shift;
    logic           in_rdy, out_vld;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  qq;
    logic [SW-1:0]  sigma;

    logic           s_vld, s_load;
    logic [CHW-1:0] s_ch;
    logic [DW-1:0]  s_dat;
    logic [SHW-1:0] s_shift;
    logic           s_in_rdy, s_out_vld;
    logic [CHW-1:0] s_out_ch;
    logic [DW-1:0]  s_qq;
    logic [SW-1:0]  s_sigma;

    int checks = 0;
    int failures = 0;

    longint         m_sig [CH];
    logic           m_vld;
    logic [CHW-1:0] m_ch;
    logic [DW-1:0]  m_qq;
    logic [SW-1:0]  m_sigma;

    wire [26:0] dut_out = {out_vld, out_ch, qq, sigma};

    always #5 ck = ~ck;

    iir_lpf_mc #(.C_DAT_W(DW), .C_CH(CH), .C_SHIFT_MAX(SM), .C_SIGNED(0)) dut (
        .CK_i(ck), .RST_i(rst), .EN_CK_i(en), .CLR_i(clr),
        .IN_VLD_i(in_vld), .IN_RDY_o(in_rdy), .IN_CH_i(in_ch), .DAT_i(dat),
        .SHIFT_i(shift), .LOAD_i(load), .OUT_VLD_o(out_vld), .OUT_RDY_i(out_rdy),
        .OUT_CH_o(out_ch), .QQ_o(qq), .SIGMA_o(sigma)
    );

    iir_lpf_mc #(.C_DAT_W(DW), .C_CH(CH), .C_SHIFT_MAX(SM), .C_SIGNED(1)) dut_s (
        .CK_i(ck), .RST_i(rst), .EN_CK_i(en), .CLR_i(clr),
        .IN_VLD_i(s_vld), .IN_RDY_o(s_in_rdy), .IN_CH_i(s_ch), .DAT_i(s_dat),
        .SHIFT_i(s_shift), .LOAD_i(s_load), .OUT_VLD_o(s_out_vld), .OUT_RDY_i(out_rdy),
        .OUT_CH_o(s_out_ch), .QQ_o(s_qq), .SIGMA_o(s_sigma)
    );

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Filter rule as plain integer arithmetic on the 2^8-scaled state.
    function automatic longint model_upd(input longint sig, input longint d, input int s, input bit ld);
        longint ds;
        longint div;
        int se;
        ds = d * 256;
        se = (s > SM) ? SM : s;
        div = longint'(1) << se;
        if (ld || se == 0) return ds;
        return sig + fdiv(ds, div) - fdiv(sig, div);
    endfunction

    function automatic logic exp_rdy();
        return en && !rst && !clr && (!m_vld || out_rdy);
    endfunction

    function automatic logic [26:0] exp_out();
        return {m_vld, m_ch, m_qq, m_sigma};
    endfunction

    task automatic tick();
        bit acc;
        longint nv;
        acc = in_vld && exp_rdy();
        nv = model_upd(m_sig[in_ch], longint'(dat), int'(shift), load);
        @(posedge ck);
        if (rst) begin
            for (int i = 0; i < CH; i++) m_sig[i] = 0;
            m_vld = 1'b0; m_ch = '0; m_qq = '0; m_sigma = '0;
        end else if (en) begin
            if (clr) begin
                for (int i = 0; i < CH; i++) m_sig[i] = 0;
            end else if (acc) begin
                m_sig[in_ch] = nv;
            end
            if (acc) begin
                m_vld = 1'b1; m_ch = in_ch; m_qq = DW'(fdiv(nv, 256)); m_sigma = SW'(nv);
            end else if (out_rdy) begin
                m_vld = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; out_rdy = 1'b1;
        in_vld = 1'b0; in_ch = '0; dat = '0; shift = '0; load = 1'b0;
        s_vld = 1'b0; s_ch = '0; s_dat = '0; s_shift = '0; s_load = 1'b0;
        tick();
        tick();
        in_vld = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_rdy got=%b want=0", in_rdy);
        end
        checks++;
        if (dut_out !== 27'd0) begin
            failures++; $display("[TB] FAIL reset_out got=%h want=0", dut_out);
        end
        checks++;
        if ({s_out_vld, s_out_ch, s_qq, s_sigma} !== 27'd0) begin
            failures++; $display("[TB] FAIL reset_out_signed got=%h want=0", {s_out_vld, s_out_ch, s_qq, s_sigma});
        end
        in_vld = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_settle();
        int maxq;
        maxq = 0;
        in_vld = 1'b1; in_ch = 2'd0; dat = 8'd200; shift = 4'd8; load = 1'b0;
        for (int b = 1; b <= 2500; b++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("[TB] FAIL settle_beat%0d got=%h want=%h", b, dut_out, exp_out());
            end
            if (int'(qq) > maxq) maxq = int'(qq);
            if (b == 1) begin
                checks++;
                if (qq !== 8'd0 || sigma !== 16'd200) begin
                    failures++; $display("[TB] FAIL settle_first got qq=%0d sigma=%0d want qq=0 sigma=200", qq, sigma);
                end
            end
            if (b == 256) begin
                checks++;
                if (qq < 8'd125 || qq > 8'd127) begin
                    failures++; $display("[TB] FAIL settle_256 got qq=%0d want 125..127", qq);
                end
            end
        end
        checks++;
        if (qq !== 8'd200) begin
            failures++; $display("[TB] FAIL settle_final got qq=%0d want 200", qq);
        end
        checks++;
        if (maxq > 200) begin
            failures++; $display("[TB] FAIL settle_overshoot got max=%0d want <=200", maxq);
        end
    endtask

    task automatic test_bypass();
        in_vld = 1'b1; in_ch = 2'd1; dat = 8'd37; shift = 4'd0; load = 1'b0;
        tick();
        in_vld = 1'b0;
        checks++;
        if ({out_vld, out_ch, qq, sigma} !== {1'b1, 2'd1, 8'd37, 16'd9472}) begin
            failures++; $display("[TB] FAIL bypass got vld=%b ch=%0d qq=%0d sigma=%0d want 1/1/37/9472", out_vld, out_ch, qq, sigma);
        end
        checks++;
        if (dut_out !== exp_out()) begin
            failures++; $display("[TB] FAIL bypass_model got=%h want=%h", dut_out, exp_out());
        end
        tick();
    endtask

    task automatic test_interleave();
        int ch1_beats;
        ch1_beats = 0;
        in_vld = 1'b1; shift = 4'd2; load = 1'b0;
        for (int b = 0; b < 160; b++) begin
            in_ch = (b % 2 == 0) ? 2'd1 : 2'd2;
            dat   = (b % 2 == 0) ? 8'd255 : 8'd0;
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("[TB] FAIL interleave_beat%0d got=%h want=%h", b, dut_out, exp_out());
            end
            if (out_ch == 2'd2) begin
                checks++;
                if (qq !== 8'd0) begin
                    failures++; $display("[TB] FAIL interleave_ch2 got qq=%0d want 0", qq);
                end
            end else begin
                ch1_beats++;
                if (ch1_beats >= 64) begin
                    checks++;
                    if (qq !== 8'd255) begin
                        failures++; $display("[TB] FAIL interleave_ch1_beat%0d got qq=%0d want 255", ch1_beats, qq);
                    end
                end
            end
        end
        in_vld = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [26:0] snap;
        in_vld = 1'b1; in_ch = 2'd3; dat = 8'd77; shift = 4'd3; load = 1'b0; out_rdy = 1'b0;
        tick();
        snap = dut_out;
        checks++;
        if (dut_out !== exp_out()) begin
            failures++; $display("[TB] FAIL bp_first got=%h want=%h", dut_out, exp_out());
        end
        for (int c = 0; c < 4; c++) begin
            dat = 8'($urandom_range(0, 255));
            #1;
            checks++;
            if (in_rdy !== 1'b0) begin
                failures++; $display("[TB] FAIL bp_rdy%0d got=%b want=0", c, in_rdy);
            end
            tick();
            checks++;
            if (dut_out !== snap || dut_out !== exp_out()) begin
                failures++; $display("[TB] FAIL bp_hold%0d got=%h want=%h", c, dut_out, exp_out());
            end
        end
        out_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            dat = 8'($urandom_range(0, 255));
            shift = 4'($urandom_range(1, 8));
            #1;
            checks++;
            if (in_rdy !== 1'b1) begin
                failures++; $display("[TB] FAIL bp_release_rdy%0d got=%b want=1", c, in_rdy);
            end
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("[TB] FAIL bp_release%0d got=%h want=%h", c, dut_out, exp_out());
            end
        end
        in_vld = 1'b0;
        tick();
    endtask

    task automatic test_load_clear();
        in_vld = 1'b1; in_ch = 2'd3; dat = 8'd100; shift = 4'd5; load = 1'b1;
        tick();
        checks++;
        if (qq !== 8'd100 || sigma !== 16'd25600) begin
            failures++; $display("[TB] FAIL load got qq=%0d sigma=%0d want 100/25600", qq, sigma);
        end
        load = 1'b0; dat = 8'd55; clr = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b0) begin
            failures++; $display("[TB] FAIL clear_rdy got=%b want=0", in_rdy);
        end
        tick();
        checks++;
        if (dut_out !== exp_out()) begin
            failures++; $display("[TB] FAIL clear_drain got=%h want=%h", dut_out, exp_out());
        end
        clr = 1'b0; dat = 8'd0; shift = 4'd8;
        tick();
        checks++;
        if ({out_vld, out_ch, qq, sigma} !== {1'b1, 2'd3, 8'd0, 16'd0}) begin
            failures++; $display("[TB] FAIL after_clear got vld=%b ch=%0d qq=%0d sigma=%0d want 1/3/0/0", out_vld, out_ch, qq, sigma);
        end
        in_vld = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        in_vld = 1'b1; in_ch = 2'd2; dat = 8'd90; shift = 4'd1; out_rdy = 1'b0;
        tick();
        en = 1'b0; out_rdy = 1'b1; dat = 8'd10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_rdy !== 1'b0) begin
                failures++; $display("[TB] FAIL en_rdy%0d got=%b want=0", c, in_rdy);
            end
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("[TB] FAIL en_freeze%0d got=%h want=%h", c, dut_out, exp_out());
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (dut_out !== exp_out()) begin
            failures++; $display("[TB] FAIL en_resume got=%h want=%h", dut_out, exp_out());
        end
        in_vld = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        in_vld = 1'b1; in_ch = 2'd0; dat = 8'd150; shift = 4'd0; out_rdy = 1'b0;
        tick();
        in_vld = 1'b0; rst = 1'b1; clr = 1'b1;
        tick();
        checks++;
        if (dut_out !== 27'd0) begin
            failures++; $display("[TB] FAIL reset_mid got=%h want=0", dut_out);
        end
        rst = 1'b0; clr = 1'b0; out_rdy = 1'b1;
        in_vld = 1'b1; shift = 4'd8; dat = 8'd0;
        tick();
        checks++;
        if (dut_out !== exp_out()) begin
            failures++; $display("[TB] FAIL reset_mid_state got=%h want=%h", dut_out, exp_out());
        end
        in_vld = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            clr     = ($urandom_range(0, 31) == 0);
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            in_ch   = 2'($urandom_range(0, 3));
            dat     = 8'($urandom_range(0, 255));
            shift   = 4'($urandom_range(0, 15));
            load    = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (in_rdy !== exp_rdy()) begin
                failures++; $display("[TB] FAIL rand_rdy%0d got=%b want=%b", c, in_rdy, exp_rdy());
            end
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("[TB] FAIL rand_out%0d got=%h want=%h", c, dut_out, exp_out());
            end
        end
        en = 1'b1; clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; load = 1'b0;
        tick();
    endtask

    task automatic test_signed();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_vld = 1'b1; s_ch = 2'd0; s_dat = 8'hFF; s_shift = 4'd4; s_load = 1'b0;
        tick();
        checks++;
        if ({s_out_vld, s_qq, s_sigma} !== {1'b1, 8'hFF, 16'hFFF0}) begin
            failures++; $display("[TB] FAIL signed_m1 got vld=%b qq=%h sigma=%h want 1/ff/fff0", s_out_vld, s_qq, s_sigma);
        end
        s_dat = 8'h80; s_shift = 4'd0;
        tick();
        checks++;
        if ({s_qq, s_sigma} !== {8'h80, 16'h8000}) begin
            failures++; $display("[TB] FAIL signed_m128 got qq=%h sigma=%h want 80/8000", s_qq, s_sigma);
        end
        s_dat = 8'hCE; s_shift = 4'd3;
        for (int b = 0; b < 200; b++) tick();
        checks++;
        if (s_qq !== 8'hCE) begin
            failures++; $display("[TB] FAIL signed_settle got qq=%h want ce", s_qq);
        end
        s_vld = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_settle();
        test_bypass();
        test_interleave();
        test_backpressure();
        test_load_clear();
        test_enable();
        test_reset_midstream();
        test_random();
        test_signed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
